// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared types and default sizes for the LFSR sequence controller
//
// Purpose : FSM state encoding and default widths used by lfsr_core and
//           lfsr_seq_ctrl.
// Contents: LFSR_N_DEF      default LFSR width
//           LFSR_CNT_W_DEF  default word-count width
//           lfsr_state_t    controller FSM states

package lfsr_pkg;

  localparam int LFSR_N_DEF     = 8;
  localparam int LFSR_CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } lfsr_state_t;

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - LFSR state register with parallel load and single step
//
// Purpose : Holds the LFSR state. Load has priority over step. One step
//           shifts right and feeds the parity of (state & char_poly) into
//           the MSB.
// Ports   : clk        rising-edge clock
//           reset      asynchronous, active-high; clears seq
//           load       write load_val into seq
//           load_val   value written on load
//           step       advance the LFSR by one position
//           char_poly  feedback tap mask
//           seq        current LFSR state

module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int N = LFSR_N_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         step,
  input  logic [N-1:0] char_poly,
  output logic [N-1:0] seq
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq <= '0;
    end else if (load) begin
      seq <= load_val;
    end else if (step) begin
      seq <= {^(seq & char_poly), seq[N-1:1]};
    end
  end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// rtl/lfsr_seq_ctrl.sv - run controller emitting a counted LFSR word stream
//
// Purpose : On start, latches seed/char_poly/count, loads the LFSR and emits
//           count words with valid/ready handshaking. Rejects seed==0 or
//           count==0 with an err pulse. Optional period detection is built
//           when LFSR_PERIOD_DETECT_EN is defined; otherwise period and
//           period_valid are tied to 0.
// Ports   : clk, reset     clock; asynchronous active-high reset
//           start, abort   run request (IDLE only) / cancel (LOAD, RUN)
//           seed, char_poly, count   run configuration, latched on start
//           out_valid, out_ready, out_data   word stream
//           busy           high in LOAD or RUN
//           done, err      one-cycle completion / rejection pulses
//           period, period_valid     detected sequence period

module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int N     = LFSR_N_DEF,
  parameter int CNT_W = LFSR_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [N-1:0]     seed,
  input  logic [N-1:0]     char_poly,
  input  logic [CNT_W-1:0] count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] period,
  output logic             period_valid
);

  lfsr_state_t      state;
  logic [N-1:0]     seed_q;
  logic [N-1:0]     poly_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] remaining;
  logic             rejected;
  logic             xfer;
  logic [N-1:0]     seq;

  assign out_valid = (state == ST_RUN);
  // A cycle with abort is never a transfer, so the LFSR does not advance.
  assign xfer      = out_valid && out_ready && !abort;
  assign busy      = (state == ST_LOAD) || (state == ST_RUN);
  // DONE is shared by normal completion and rejection; rejected selects the pulse.
  assign done      = (state == ST_DONE) && !rejected;
  assign err       = (state == ST_DONE) && rejected;
  assign out_data  = seq;

  lfsr_core #(
    .N(N)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .load      (state == ST_LOAD),
    .load_val  (seed_q),
    .step      (xfer),
    .char_poly (poly_q),
    .seq       (seq)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      seed_q    <= '0;
      poly_q    <= '0;
      count_q   <= '0;
      remaining <= '0;
      rejected  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // start wins over abort here; abort has no meaning in IDLE.
          if (start) begin
            seed_q  <= seed;
            poly_q  <= char_poly;
            count_q <= count;
            if (seed == '0 || count == '0) begin
              rejected <= 1'b1;
              state    <= ST_DONE;
            end else begin
              rejected <= 1'b0;
              state    <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            remaining <= count_q;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (xfer) begin
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef LFSR_PERIOD_DETECT_EN
  logic [CNT_W-1:0] xfer_cnt;
  logic [CNT_W-1:0] period_q;
  logic             period_valid_q;
  logic [N-1:0]     seq_next;

  // Look-ahead of the core's step so the period is captured on the very
  // transfer that returns the LFSR to the seed, not a cycle later.
  assign seq_next = {^(seq & poly_q), seq[N-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xfer_cnt       <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
    end else begin
      if (state == ST_IDLE && start) begin
        period_q       <= '0;
        period_valid_q <= 1'b0;
      end
      if (state == ST_LOAD) begin
        xfer_cnt <= '0;
      end else if (xfer) begin
        xfer_cnt <= xfer_cnt + CNT_W'(1);
        if (!period_valid_q && seq_next == seed_q) begin
          period_q       <= xfer_cnt + CNT_W'(1);
          period_valid_q <= 1'b1;
        end
      end
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
`else
  assign period       = '0;
  assign period_valid = 1'b0;
`endif

endmodule

// File: doc/lfsr_seq_ctrl.md
LFSR_SEQ_CTRL -- requirements
Module: lfsr_seq_ctrl

Interface
REQ-001 Parameter N, default 8, LFSR width in bits.
REQ-002 Parameter CNT_W, default 16, width of the word-count field.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request a run; sampled only in IDLE.
REQ-006 abort  input  1  synchronous cancel of an active run.
REQ-007 seed  input  N  initial LFSR state, latched on accepted start.
REQ-008 char_poly  input  N  feedback tap mask, latched on accepted start.
REQ-009 count  input  CNT_W  number of words to emit, latched on accepted start.
REQ-010 out_valid  output  1  out_data is valid.
REQ-011 out_ready  input  1  consumer accepts out_data.
REQ-012 out_data  output  N  current LFSR state.
REQ-013 busy  output  1  high in LOAD or RUN.
REQ-014 done  output  1  one-cycle pulse when a run completes normally.
REQ-015 err  output  1  one-cycle pulse when a start is rejected.
REQ-016 period  output  CNT_W  detected sequence period; see Configuration.
REQ-017 period_valid  output  1  period holds a valid result.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, RUN and DONE.
REQ-019 In IDLE, start=1 SHALL latch seed, char_poly and count.
- If the latched seed==0 or count==0: go to DONE with err pulsed; done is not pulsed.
- Otherwise: go to LOAD.
REQ-020 LOAD SHALL write the latched seed into the LFSR, set remaining=count, and move to RUN after exactly 1 cycle.
REQ-021 In RUN, out_valid SHALL be 1 and out_data SHALL equal the LFSR state, so the first word emitted is the seed.
REQ-022 A transfer SHALL occur when out_valid and out_ready are both 1 in the same cycle. On each transfer the LFSR SHALL step once:
- new[N-1] = XOR-reduce(state AND poly)
- new[N-2:0] = state[N-1:1]
- remaining decrements by 1.
REQ-023 With no transfer, LFSR state and out_data SHALL hold; stalls of any length are allowed.
REQ-024 A transfer with remaining==1 SHALL move the FSM to DONE; out_valid is 0 from the next cycle.
REQ-025 DONE SHALL last 1 cycle, pulse done (unless entered on a rejected start), and return to IDLE.
REQ-026 start outside IDLE SHALL be ignored.
REQ-027 abort in LOAD or RUN SHALL force IDLE on the next edge, with no done pulse, dropping out_valid; abort takes priority over a simultaneous transfer.
REQ-028 remaining SHALL be CNT_W bits wide; count of 2^CNT_W-1 SHALL run without wrap.
REQ-029 start and abort asserted together in IDLE SHALL be treated as start only.

Reset
REQ-030 On reset, the block SHALL:
- enter IDLE;
- clear the LFSR, latched config, remaining, period and period_valid to 0;
- drive out_valid, busy, done and err to 0.
REQ-031 Reset asserted mid-run SHALL drop out_valid immediately, with no done pulse.

Configuration
REQ-032 With LFSR_PERIOD_DETECT_EN defined, the block SHALL count transfers since LOAD and capture period on the first transfer after which the LFSR state equals the latched seed, then set period_valid.
- period_valid stays set until the next accepted start, which clears it.
- If the run ends first, period stays 0 and period_valid stays 0.
REQ-033 Without LFSR_PERIOD_DETECT_EN, period SHALL be tied to 0, period_valid to 0, and no comparator or counter logic is synthesized.

Structure
REQ-034 A shared package lfsr_pkg SHALL hold the FSM state enum and the default N and CNT_W constants.
REQ-035 The LFSR register and step logic SHALL be a sub-module lfsr_core with ports:
- clk, reset, load, load_val, step, char_poly, seq.

Verification
REQ-036 N=8, seed=0x01, poly=0x09, count=7, out_ready=1:
- out_data = 01,80,40,20,10,08,84 on consecutive cycles;
- done pulses once.
REQ-037 Same stimulus with out_ready toggling 1,0,1,0: each word is held while out_ready=0; same 7-word sequence, no duplicates.
REQ-038 seed=0x00, count=4: err pulses 1 cycle, out_valid stays 0, done stays 0.
REQ-039 abort asserted after the third transfer: out_valid is 0 next cycle, busy is 0, no done pulse; a new start is accepted afterwards.
REQ-040 reset asserted mid-RUN: all outputs are 0 asynchronously; start after release runs normally.
REQ-041 With LFSR_PERIOD_DETECT_EN, N=4, seed=0x1, poly=0x3, count=20: period=15 and period_valid=1 before done.
